seg7_scan_mux: RTL and testbench

- Time-multiplexed scan stage for the 4-digit common-anode 7-segment display. It sits directly upstream of the hex-to-segment decoder.
- Holds a 16-bit display value and rotates through the four digits at a fixed refresh rate.
- Each step presents one 4-bit nibble on `hex` to the decoder and drives the matching active-low anode.
- Provides tear-free updates via a shadow register, plus optional leading-zero blanking.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_scan_mux_if.sv | 14 +
 rtl/refresh_prescaler.sv | 18 +
 rtl/seg7_scan_mux.sv | 64 ++++++
 tb/tb_seg7_scan_mux.sv | 135 +++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: display constants shared by the scan mux, hex decoder and board top.
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic DP_OFF = 1'b1;
  typedef struct packed {
    logic [15:0] data;
    logic [3:0] dp;
  } frame_t;
  function automatic logic [3:0] an_pattern(input logic [1:0] k);
    return k == 2'd0 ? AN_D0 : k == 2'd1 ? AN_D1 : k == 2'd2 ? AN_D2 : AN_D3;
  endfunction
endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: load/data from upstream and scanned digit outputs to the decoder.
interface seg7_scan_mux_if;
  logic load;
  logic [15:0] data_in;
  logic [3:0] dp_in;
  logic lz_blank;
  logic [3:0] hex;
  logic dp;
  logic [3:0] anodes;
  logic [1:0] digit_sel;
  logic frame_done;
  modport master(output load, data_in, dp_in, lz_blank, input hex, dp, anodes, digit_sel, frame_done);
  modport slave(input load, data_in, dp_in, lz_blank, output hex, dp, anodes, digit_sel, frame_done);
endinterface

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: counts 0..REFRESH_DIV-1, tick high on the final count.
module refresh_prescaler #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  output logic tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == CNT_W'(REFRESH_DIV - 1);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: 4-digit scan with shadow/commit at frame wrap and leading-zero blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  seg7_scan_mux_if.slave bus
);
  logic tick, last, commit, blank;
  logic pending_q, pending_d;
  frame_t shadow_q, shadow_d, active_q, active_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] hex_q, hex_d, an_q, an_d, nz;
  logic dp_q, dp_d, fd_q, fd_d;
  refresh_prescaler #(.REFRESH_DIV(REFRESH_DIV), .CNT_W(CNT_W)) u_pre (
    .clk(clk),
    .reset(reset),
    .tick(tick)
  );
  always_comb begin
    last = tick && sel_q == 2'd3;
    commit = last && pending_q;
    shadow_d = bus.load ? frame_t'{data: bus.data_in, dp: bus.dp_in} : shadow_q;
    pending_d = commit ? 1'b0 : (bus.load | pending_q);
    active_d = commit ? shadow_d : active_q;
    sel_d = tick ? sel_q + 2'd1 : sel_q;
    nz = {|active_d.data[15:12], |active_d.data[11:8], |active_d.data[7:4], |active_d.data[3:0]};
    // digit k is a leading zero when every nibble from k upward is zero
    blank = bus.lz_blank && sel_d != 2'd0 && (nz >> sel_d) == 4'b0000;
    hex_d = tick ? active_d.data[{sel_d, 2'b00} +: 4] : hex_q;
    an_d = tick ? (blank ? AN_OFF : an_pattern(sel_d)) : an_q;
    dp_d = tick ? (blank ? DP_OFF : ~active_d.dp[sel_d]) : dp_q;
    fd_d = last;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      pending_q <= 1'b0;
      sel_q <= 2'd0;
      hex_q <= 4'h0;
      an_q <= AN_D0;
      dp_q <= DP_OFF;
      fd_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pending_q <= pending_d;
      sel_q <= sel_d;
      hex_q <= hex_d;
      an_q <= an_d;
      dp_q <= dp_d;
      fd_q <= fd_d;
    end
  end
  assign bus.hex = hex_q;
  assign bus.anodes = an_q;
  assign bus.dp = dp_q;
  assign bus.digit_sel = sel_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: random and directed scan stimulus checked against a cycle-count reference model.
module tb_seg7_scan_mux;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  seg7_scan_mux_if bus ();
  seg7_scan_mux #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] hex;
    logic dp;
    logic [3:0] an;
    logic [1:0] sel;
    logic fd;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] m_sh, m_act;
  logic [3:0] m_sdp, m_adp;
  bit m_pend;
  bit cur_lz;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("digit_sel", 32'(bus.digit_sel), 32'(e.sel));
        chk("hex", 32'(bus.hex), 32'(e.hex));
        chk("anodes", 32'(bus.anodes), 32'(e.an));
        chk("dp", 32'(bus.dp), 32'(e.dp));
        chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
      end
    end
  end
  exp_t e_cur;
  task automatic step(input bit rst, input bit ld, input logic [15:0] d, input logic [3:0] p);
    bit boundary, last, commit;
    int k;
    @(negedge clk);
    reset = rst;
    bus.load = ld;
    bus.data_in = d;
    bus.dp_in = p;
    bus.lz_blank = cur_lz;
    if (rst) begin
      cyc = 0;
      m_sh = 0; m_act = 0; m_sdp = 0; m_adp = 0; m_pend = 0;
      e_cur = '{hex: 4'h0, dp: 1'b1, an: 4'b1110, sel: 2'd0, fd: 1'b0};
    end else begin
      boundary = cyc % DIV == DIV - 1;
      last = boundary && (cyc / DIV) % 4 == 3;
      commit = last && m_pend;
      if (ld) begin m_sh = d; m_sdp = p; end
      if (commit) begin m_act = m_sh; m_adp = m_sdp; end
      m_pend = commit ? 1'b0 : (m_pend || ld);
      cyc++;
      e_cur.fd = last;
      if (boundary) begin
        k = (cyc / DIV) % 4;
        e_cur.sel = 2'(k);
        e_cur.hex = 4'((m_act >> (4 * k)) & 16'hF);
        if (cur_lz && k > 0 && (m_act >> (4 * k)) == 0) begin
          e_cur.an = 4'b1111;
          e_cur.dp = 1'b1;
        end else begin
          e_cur.an = ~(4'b0001 << k);
          e_cur.dp = !m_adp[k];
        end
      end
    end
    q.push_back(e_cur);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 4'h0);
  endtask
  task automatic load_at(input int phase, input logic [15:0] d, input logic [3:0] p);
    while (cyc % (4 * DIV) != phase) step(0, 0, 16'h0, 4'h0);
    step(0, 1, d, p);
  endtask
  initial begin
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    bus.load = 0; bus.data_in = 0; bus.dp_in = 0; bus.lz_blank = 0;
    cur_lz = 0;
    step(1, 0, 16'h0, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    step(0, 1, 16'h1234, 4'b0000);
    idle(40);
    load_at(5, 16'hABCD, 4'b0000);
    idle(36);
    load_at(1, 16'h1111, 4'b0000);
    load_at(6, 16'h2222, 4'b0000);
    load_at(15, 16'h3333, 4'b0000);
    idle(36);
    cur_lz = 1;
    step(0, 1, 16'h0050, 4'b0000);
    idle(36);
    step(0, 1, 16'h0000, 4'b1111);
    idle(36);
    cur_lz = 0;
    step(0, 1, 16'h1234, 4'b0100);
    idle(36);
    cur_lz = 1;
    step(0, 1, 16'h0005, 4'b1111);
    idle(36);
    cur_lz = 0;
    load_at(9, 16'h4321, 4'b1010);
    idle(40);
    while (cyc % (4 * DIV) != 9) step(0, 0, 16'h0, 4'h0);
    step(1, 0, 16'h0, 4'h0);
    idle(24);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(0, 299) == 0) step(1, 0, 16'h0, 4'h0);
      else if ($urandom_range(0, 11) == 0)
        step(0, 1, 16'($urandom) & masks[$urandom_range(0, 4)], 4'($urandom));
      else step(0, 0, 16'($urandom), 4'($urandom));
    end
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
